pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
Parametrised inter-stage pipeline register for the 5-stage core. It generalises the fixed EX/MEM latch in three ways: configurable payload widths, a configurable stage count, and per-stage stall/flush with a valid bit. The same block is instantiated for IF/ID, ID/EX, EX/MEM and MEM/WB, and the hazard unit drives its stall/flush inputs.

Parameters:
CTRL_W, 4, width of control bundle (RegWrite, MemtoReg, MemRead, MemWrite by default)
DATA_W, 64, width of packed datapath payload (e.g. alu_result concatenated with rs2_data)
RD_W, 5, destination register index width
DEPTH, 1, number of back-to-back register slots (>=1; values >1 used for retimed MEM)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
stall_i  in  1  hold all slots
flush_i  in  DEPTH  per-slot bubble insert; bit k targets slot k (slot DEPTH-1 drives outputs)
valid_i  in  1  upstream instruction valid
ctrl_i  in  CTRL_W  upstream control bundle
data_i  in  DATA_W  upstream payload
rd_i  in  RD_W  upstream destination register
valid_o  out  1  slot DEPTH-1 valid
ctrl_o  out  CTRL_W  slot DEPTH-1 control
data_o  out  DATA_W  slot DEPTH-1 payload
rd_o  out  RD_W  slot DEPTH-1 destination register
busy_o  out  1  OR of all slot valid bits

Behaviour:
- Reset: reset is asynchronous and active-low on rst; the clock is clk. While rst=0, every slot clears valid, ctrl, data and rd to 0. All outputs therefore read 0 and busy_o=0. Reset asserted mid-stream discards all in-flight entries immediately, without waiting for a clock edge.
- Each slot k holds {valid, ctrl, rd, data}. Slot 0's source is the input ports; slot k's source is slot k-1.
- Latency: DEPTH cycles from input to output when no stall or flush occurs.
- Per-edge priority for slot k: flush_i[k] > stall_i > advance.
- Flush: valid=0, ctrl=0, rd=0. The data field holds its old value (it is don't-care on a bubble). Flush overrides stall for that slot only. Other slots still obey stall.
- Stall without flush: the slot holds all fields unchanged.
- Advance: valid, ctrl and rd load from the source. data loads only when the source valid=1; otherwise it holds (clock-gating friendly).
- A bubble from the source (source valid=0) loads ctrl=0 and rd=0 even if ctrl_i/rd_i are non-zero. A bubble can therefore never assert RegWrite or MemWrite downstream.
- Simultaneous stall_i=1 and flush_i[k]=1: slot k becomes a bubble, and all other slots hold.
- Outputs are driven directly from slot DEPTH-1 registers with no combinational path from inputs. busy_o is a combinational OR of the slot valid bits.
- Elaboration error if DEPTH<1 or any width is <1.

Optional Feature:
Macro PIPE_STAGE_REG_PERF_EN.
- When defined, adds outputs stall_cnt_o[31:0] and bubble_cnt_o[31:0].
  - stall_cnt_o counts rising edges with stall_i=1.
  - bubble_cnt_o counts edges where slot DEPTH-1 is loaded or held with valid=0.
  - Both counters saturate at 0xFFFFFFFF and reset to 0 on rst.
- When undefined, these ports and counters do not exist, and the functional behaviour is identical.

Decomposition:
- Package pipe_pkg holds:
  - the control-bit index constants CTRL_REGWRITE=0, CTRL_MEMTOREG=1, CTRL_MEMREAD=2, CTRL_MEMWRITE=3;
  - CTRL_W_DEF=4 and RD_W_DEF=5;
  - a packed struct typedef for the default control bundle.
- Sub-module pipe_stage_slot implements one slot (flush/stall/advance logic and data enable). The top instantiates it DEPTH times in a generate loop and adds busy_o and the optional counters.

Test Plan:
1. DEPTH=1, rst held low with valid_i=1, ctrl_i=4'hF -> all outputs 0, busy_o=0. Release rst, next edge -> valid_o=1, ctrl_o=4'hF.
2. DEPTH=3, inject valid_i=1, data_i=64'hA5, rd_i=7 for one cycle then valid_i=0 -> the entry appears at the outputs exactly 3 edges later for one cycle. The following cycle shows valid_o=0, ctrl_o=0, rd_o=0, data_o=64'hA5 (held).
3. DEPTH=1, valid_o=1 with ctrl_o=4'b1001, then stall_i=1 for 4 cycles while inputs change -> outputs frozen. Deassert -> new input loads on the next edge.
4. DEPTH=2, stall_i=1 with flush_i=2'b10 -> slot 1 becomes a bubble (valid_o=0, ctrl_o=0) and slot 0 holds. Release both -> slot 0's entry emerges after 1 edge.
5. Valid_i=0 with ctrl_i=4'hF, rd_i=31 -> ctrl_o=0, rd_o=0, valid_o=0. Then assert rst asynchronously mid-cycle with pipeline full -> outputs go to 0 before the next edge.
6. With PIPE_STAGE_REG_PERF_EN: stall for 5 edges and flush the output slot twice -> stall_cnt_o=5, bubble_cnt_o≥2. Preload stall_cnt to 0xFFFFFFFE and stall 3 edges -> stall_cnt_o saturates at 0xFFFFFFFF.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers of the 5-stage core.
// Latency: none (package only).
// Backpressure: none (package only).
package pipe_pkg;

  // Bit positions inside the default control bundle
  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMTOREG = 1;
  localparam int CTRL_MEMREAD  = 2;
  localparam int CTRL_MEMWRITE = 3;

  // Default widths of the control bundle and destination register index
  localparam int CTRL_W_DEF = 4;
  localparam int RD_W_DEF   = 5;

  // Default control bundle; the last member is bit 0, matching the indices above
  typedef struct packed {
    logic memwrite;
    logic memread;
    logic memtoreg;
    logic regwrite;
  } ctrl_t;

endpackage

// File: rtl/pipe_stage_slot.sv
// One pipeline register slot holding {valid, ctrl, rd, data}; priority flush > stall > advance.
// Latency: 1 cycle from source to slot contents.
// Backpressure: stall holds every field; flush inserts a bubble even while stalled.
module pipe_stage_slot
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = 64,
  parameter int RD_W   = RD_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              stall,
  input  logic              src_valid,
  input  logic [CTRL_W-1:0] src_ctrl,
  input  logic [RD_W-1:0]   src_rd,
  input  logic [DATA_W-1:0] src_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [RD_W-1:0]   rd,
  output logic [DATA_W-1:0] data
);

  // Loads happen only on advance; data additionally only when carrying a real instruction
  logic advance;
  logic data_en;

  assign advance = !flush && !stall;
  assign data_en = advance && src_valid;

  // Control side: a bubble (flushed or invalid source) always carries zero ctrl/rd
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      ctrl  <= '0;
      rd    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      ctrl  <= '0;
      rd    <= '0;
    end else if (!stall) begin
      valid <= src_valid;
      ctrl  <= src_valid ? src_ctrl : '0;
      rd    <= src_valid ? src_rd   : '0;
    end
  end

  // Payload side: enable-only register so bubbles leave the wide data untouched
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data <= '0;
    end else if (data_en) begin
      data <= src_data;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register (DEPTH slots) with per-slot flush and global stall.
// Latency: DEPTH cycles input to output; outputs come straight from the last slot's registers.
// Backpressure: stall_i freezes all slots not being flushed. Optional counters: PIPE_STAGE_REG_PERF_EN.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = 64,
  parameter int RD_W   = RD_W_DEF,
  parameter int DEPTH  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic [DEPTH-1:0]  flush_i,
  input  logic              valid_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [RD_W-1:0]   rd_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  output logic [RD_W-1:0]   rd_o,
  output logic              busy_o
`ifdef PIPE_STAGE_REG_PERF_EN
  ,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       bubble_cnt_o
`endif
);

  if (DEPTH < 1 || CTRL_W < 1 || DATA_W < 1 || RD_W < 1) begin : g_bad_param
    $error("pipe_stage_reg: DEPTH and all widths must be >= 1");
  end

  // Per-slot source and state; slot k's source is slot k-1, slot 0's is the input ports
  logic [DEPTH-1:0]  src_valid;
  logic [CTRL_W-1:0] src_ctrl   [DEPTH];
  logic [RD_W-1:0]   src_rd     [DEPTH];
  logic [DATA_W-1:0] src_data   [DEPTH];
  logic [DEPTH-1:0]  slot_valid;
  logic [CTRL_W-1:0] slot_ctrl  [DEPTH];
  logic [RD_W-1:0]   slot_rd    [DEPTH];
  logic [DATA_W-1:0] slot_data  [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_slot
    if (k == 0) begin : g_src_in
      assign src_valid[k] = valid_i;
      assign src_ctrl[k]  = ctrl_i;
      assign src_rd[k]    = rd_i;
      assign src_data[k]  = data_i;
    end else begin : g_src_prev
      assign src_valid[k] = slot_valid[k-1];
      assign src_ctrl[k]  = slot_ctrl[k-1];
      assign src_rd[k]    = slot_rd[k-1];
      assign src_data[k]  = slot_data[k-1];
    end

    pipe_stage_slot #(
      .CTRL_W (CTRL_W),
      .DATA_W (DATA_W),
      .RD_W   (RD_W)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush_i[k]),
      .stall     (stall_i),
      .src_valid (src_valid[k]),
      .src_ctrl  (src_ctrl[k]),
      .src_rd    (src_rd[k]),
      .src_data  (src_data[k]),
      .valid     (slot_valid[k]),
      .ctrl      (slot_ctrl[k]),
      .rd        (slot_rd[k]),
      .data      (slot_data[k])
    );
  end

  assign valid_o = slot_valid[DEPTH-1];
  assign ctrl_o  = slot_ctrl[DEPTH-1];
  assign rd_o    = slot_rd[DEPTH-1];
  assign data_o  = slot_data[DEPTH-1];
  assign busy_o  = |slot_valid;

`ifdef PIPE_STAGE_REG_PERF_EN
  // Valid bit the output slot will hold after this edge (same priority as the slot itself)
  logic last_valid_nxt;

  assign last_valid_nxt = flush_i[DEPTH-1] ? 1'b0 :
                          stall_i          ? slot_valid[DEPTH-1] :
                                             src_valid[DEPTH-1];

  // Saturating event counters for stall edges and output-slot bubbles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_o  <= '0;
      bubble_cnt_o <= '0;
    end else begin
      if (stall_i && stall_cnt_o != 32'hFFFF_FFFF) begin
        stall_cnt_o <= stall_cnt_o + 32'd1;
      end
      if (!last_valid_nxt && bubble_cnt_o != 32'hFFFF_FFFF) begin
        bubble_cnt_o <= bubble_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg at DEPTH 1, 2 and 3 sharing one input stream.
// Latency: inputs driven on falling edges, outputs sampled on the following falling edge.
// Backpressure: stall/flush exercised by a vector table plus directed multi-cycle sequences.
module tb_pipe_stage_reg;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        valid_i;
  logic [3:0]  ctrl_i;
  logic [63:0] data_i;
  logic [4:0]  rd_i;
  logic [0:0]  flush1;
  logic [1:0]  flush2;
  logic [2:0]  flush3;

  logic        v1, v2, v3, b1, b2, b3;
  logic [3:0]  c1, c2, c3;
  logic [63:0] d1, d2, d3;
  logic [4:0]  r1, r2, r3;
`ifdef PIPE_STAGE_REG_PERF_EN
  logic [31:0] sc1, bc1, sc2, bc2, sc3, bc3;
`endif

  int errors = 0;
  int checks = 0;

  pipe_stage_reg #(.CTRL_W(4), .DATA_W(64), .RD_W(5), .DEPTH(1)) dut1 (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush1), .valid_i(valid_i),
    .ctrl_i(ctrl_i), .data_i(data_i), .rd_i(rd_i), .valid_o(v1), .ctrl_o(c1),
    .data_o(d1), .rd_o(r1), .busy_o(b1)
`ifdef PIPE_STAGE_REG_PERF_EN
    , .stall_cnt_o(sc1), .bubble_cnt_o(bc1)
`endif
  );

  pipe_stage_reg #(.CTRL_W(4), .DATA_W(64), .RD_W(5), .DEPTH(2)) dut2 (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush2), .valid_i(valid_i),
    .ctrl_i(ctrl_i), .data_i(data_i), .rd_i(rd_i), .valid_o(v2), .ctrl_o(c2),
    .data_o(d2), .rd_o(r2), .busy_o(b2)
`ifdef PIPE_STAGE_REG_PERF_EN
    , .stall_cnt_o(sc2), .bubble_cnt_o(bc2)
`endif
  );

  pipe_stage_reg #(.CTRL_W(4), .DATA_W(64), .RD_W(5), .DEPTH(3)) dut3 (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush3), .valid_i(valid_i),
    .ctrl_i(ctrl_i), .data_i(data_i), .rd_i(rd_i), .valid_o(v3), .ctrl_o(c3),
    .data_o(d3), .rd_o(r3), .busy_o(b3)
`ifdef PIPE_STAGE_REG_PERF_EN
    , .stall_cnt_o(sc3), .bubble_cnt_o(bc3)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic v, input logic [3:0] c,
                       input logic [4:0] r, input logic [63:0] d);
    stall_i = s;
    valid_i = v;
    ctrl_i  = c;
    rd_i    = r;
    data_i  = d;
  endtask

  typedef struct {
    logic        stall;
    logic        flush;
    logic        valid;
    logic [3:0]  ctrl;
    logic [4:0]  rd;
    logic [63:0] data;
    logic        ev;
    logic [3:0]  ec;
    logic [4:0]  er;
    logic [63:0] ed;
  } vec_t;

  vec_t tbl [10];

  initial begin
    // DEPTH=1 vector table: each row is applied for one edge, then outputs compared
    tbl[0] = '{1'b0, 1'b0, 1'b1, 4'hF, 5'd3,  64'h11, 1'b1, 4'hF, 5'd3, 64'h11};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 4'hF, 5'd31, 64'h22, 1'b0, 4'h0, 5'd0, 64'h11};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 4'h9, 5'd5,  64'h33, 1'b1, 4'h9, 5'd5, 64'h33};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 4'h3, 5'd7,  64'h44, 1'b1, 4'h9, 5'd5, 64'h33};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 4'hF, 5'd1,  64'h55, 1'b1, 4'h9, 5'd5, 64'h33};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 4'hA, 5'd9,  64'h88, 1'b1, 4'h9, 5'd5, 64'h33};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 4'h6, 5'd2,  64'h66, 1'b1, 4'h9, 5'd5, 64'h33};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 4'h4, 5'd12, 64'h99, 1'b1, 4'h4, 5'd12, 64'h99};
    tbl[8] = '{1'b1, 1'b1, 1'b1, 4'h6, 5'd2,  64'h77, 1'b0, 4'h0, 5'd0, 64'h99};
    tbl[9] = '{1'b0, 1'b0, 1'b1, 4'hA, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF,
               1'b1, 4'hA, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF};

    // Reset held low with a valid instruction at the inputs
    rst = 1'b0;
    flush1 = '0; flush2 = '0; flush3 = '0;
    drive(1'b0, 1'b1, 4'hF, 5'd4, 64'h0);
    repeat (3) @(negedge clk);
    chk("rst_valid", {63'd0, v1}, 64'd0);
    chk("rst_ctrl", {60'd0, c1}, 64'd0);
    chk("rst_rd", {59'd0, r1}, 64'd0);
    chk("rst_busy1", {63'd0, b1}, 64'd0);
    chk("rst_busy3", {63'd0, b3}, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", {63'd0, v1}, 64'd1);
    chk("post_rst_ctrl", {60'd0, c1}, 64'hF);

    // Table-driven DEPTH=1 checks
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].stall, tbl[i].valid, tbl[i].ctrl, tbl[i].rd, tbl[i].data);
      flush1 = tbl[i].flush;
      @(negedge clk);
      chk($sformatf("tbl%0d_valid", i), {63'd0, v1}, {63'd0, tbl[i].ev});
      chk($sformatf("tbl%0d_ctrl", i), {60'd0, c1}, {60'd0, tbl[i].ec});
      chk($sformatf("tbl%0d_rd", i), {59'd0, r1}, {59'd0, tbl[i].er});
      chk($sformatf("tbl%0d_data", i), d1, tbl[i].ed);
      chk($sformatf("tbl%0d_busy", i), {63'd0, b1}, {63'd0, tbl[i].ev});
    end
    flush1 = '0;

    // Drain with bubbles carrying non-zero ctrl/rd
    drive(1'b0, 1'b0, 4'hF, 5'd31, 64'h0);
    repeat (4) @(negedge clk);
    chk("drain_v3", {63'd0, v3}, 64'd0);
    chk("drain_c3", {60'd0, c3}, 64'd0);
    chk("drain_r3", {59'd0, r3}, 64'd0);
    chk("drain_busy3", {63'd0, b3}, 64'd0);

    // DEPTH=3 latency: one entry, then bubbles
    drive(1'b0, 1'b1, 4'h1, 5'd7, 64'hA5);
    @(negedge clk);
    chk("lat_e1_valid", {63'd0, v3}, 64'd0);
    chk("lat_e1_busy", {63'd0, b3}, 64'd1);
    drive(1'b0, 1'b0, 4'hF, 5'd31, 64'hDEAD);
    @(negedge clk);
    chk("lat_e2_valid", {63'd0, v3}, 64'd0);
    @(negedge clk);
    chk("lat_e3_valid", {63'd0, v3}, 64'd1);
    chk("lat_e3_ctrl", {60'd0, c3}, 64'h1);
    chk("lat_e3_rd", {59'd0, r3}, 64'd7);
    chk("lat_e3_data", d3, 64'hA5);
    @(negedge clk);
    chk("lat_e4_valid", {63'd0, v3}, 64'd0);
    chk("lat_e4_ctrl", {60'd0, c3}, 64'd0);
    chk("lat_e4_rd", {59'd0, r3}, 64'd0);
    chk("lat_e4_data", d3, 64'hA5);
    chk("lat_e4_busy", {63'd0, b3}, 64'd0);

    // DEPTH=2: stall with flush of the output slot only
    drive(1'b0, 1'b1, 4'h1, 5'd1, 64'hAA);
    @(negedge clk);
    drive(1'b0, 1'b1, 4'h2, 5'd2, 64'hBB);
    @(negedge clk);
    chk("d2_fill_valid", {63'd0, v2}, 64'd1);
    chk("d2_fill_data", d2, 64'hAA);
    drive(1'b1, 1'b1, 4'h4, 5'd3, 64'hCC);
    flush2 = 2'b10;
    @(negedge clk);
    chk("d2_flush1_valid", {63'd0, v2}, 64'd0);
    chk("d2_flush1_ctrl", {60'd0, c2}, 64'd0);
    chk("d2_flush1_rd", {59'd0, r2}, 64'd0);
    chk("d2_flush1_data", d2, 64'hAA);
    chk("d2_flush1_busy", {63'd0, b2}, 64'd1);
    drive(1'b0, 1'b0, 4'hF, 5'd31, 64'h0);
    flush2 = 2'b00;
    @(negedge clk);
    chk("d2_release_valid", {63'd0, v2}, 64'd1);
    chk("d2_release_ctrl", {60'd0, c2}, 64'h2);
    chk("d2_release_rd", {59'd0, r2}, 64'd2);
    chk("d2_release_data", d2, 64'hBB);
    @(negedge clk);
    chk("d2_empty_busy", {63'd0, b2}, 64'd0);

    // DEPTH=2: stall with flush of slot 0 only; output slot holds
    drive(1'b0, 1'b1, 4'h8, 5'd8, 64'h1234);
    @(negedge clk);
    drive(1'b0, 1'b1, 4'h9, 5'd9, 64'h5678);
    @(negedge clk);
    drive(1'b1, 1'b1, 4'h3, 5'd3, 64'h9ABC);
    flush2 = 2'b01;
    @(negedge clk);
    chk("d2_f0_hold_valid", {63'd0, v2}, 64'd1);
    chk("d2_f0_hold_ctrl", {60'd0, c2}, 64'h8);
    chk("d2_f0_hold_data", d2, 64'h1234);
    drive(1'b0, 1'b0, 4'h0, 5'd0, 64'h0);
    flush2 = 2'b00;
    @(negedge clk);
    chk("d2_f0_bubble_valid", {63'd0, v2}, 64'd0);
    chk("d2_f0_bubble_ctrl", {60'd0, c2}, 64'd0);

    // Asynchronous reset mid-cycle with DEPTH=3 full
    drive(1'b0, 1'b1, 4'hF, 5'd15, 64'h77);
    repeat (3) @(negedge clk);
    chk("full_busy3", {63'd0, b3}, 64'd1);
    chk("full_valid3", {63'd0, v3}, 64'd1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid3", {63'd0, v3}, 64'd0);
    chk("arst_ctrl3", {60'd0, c3}, 64'd0);
    chk("arst_rd3", {59'd0, r3}, 64'd0);
    chk("arst_data3", d3, 64'd0);
    chk("arst_busy3", {63'd0, b3}, 64'd0);
    chk("arst_busy1", {63'd0, b1}, 64'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 4'h0, 5'd0, 64'h0);
    rst = 1'b1;

`ifdef PIPE_STAGE_REG_PERF_EN
    // Counters: five stall edges, then two flushes of the output slot
    drive(1'b1, 1'b0, 4'h0, 5'd0, 64'h0);
    repeat (5) @(negedge clk);
    drive(1'b0, 1'b0, 4'h0, 5'd0, 64'h0);
    flush1 = 1'b1;
    repeat (2) @(negedge clk);
    flush1 = 1'b0;
    chk("perf_stall_cnt", {32'd0, sc1}, 64'd5);
    chk("perf_bubble_ge2", {63'd0, (bc1 >= 32'd2)}, 64'd1);
    chk("perf_stall_cnt3", {32'd0, sc3}, 64'd5);
`endif

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
